// File: rtl/cdb_arbiter_if.sv
// Result bus between the execution units and the CDB arbiter.
// The master side (execution units and CDB consumers) drives per-source results
// and observes the broadcast. The slave side (the arbiter) accepts results and
// drives the registered broadcast.
interface cdb_arbiter_if #(
  parameter int NUM_SRC   = 3,
  parameter int SRC_IDX_W = 2,
  parameter int ROB_W     = 5,
  parameter int DATA_W    = 32
);
  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC*ROB_W-1:0]  src_rob_id;
  logic [NUM_SRC*DATA_W-1:0] src_val;
  logic [NUM_SRC-1:0]        src_ready;
  logic                      cdb_valid;
  logic [ROB_W-1:0]          cdb_rob_id;
  logic [DATA_W-1:0]         cdb_val;
  logic [SRC_IDX_W-1:0]      cdb_src;
  logic                      pending;

  modport master (
    output src_valid, src_rob_id, src_val,
    input  src_ready, cdb_valid, cdb_rob_id, cdb_val, cdb_src, pending
  );

  modport slave (
    input  src_valid, src_rob_id, src_val,
    output src_ready, cdb_valid, cdb_rob_id, cdb_val, cdb_src, pending
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: one hold slot per execution unit, one result per
// cycle broadcast on a registered CDB feeding the ROB write port and the
// RS/LSB wakeup snoop. Grant order is oldest-ROB-entry-first relative to the
// ROB head (AGE_PRIO=1) or round-robin over the sources (AGE_PRIO=0).
module cdb_arbiter #(
  parameter int NUM_SRC   = 3,
  parameter int SRC_IDX_W = 2,
  parameter int ROB_W     = 5,
  parameter int DATA_W    = 32,
  parameter int AGE_PRIO  = 1
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             rdy_in,
  input  logic             clear_in,
  input  logic [ROB_W-1:0] rob_head_in,
  cdb_arbiter_if.slave     bus
);

  // Hold slots
  logic [NUM_SRC-1:0] slot_v_q, slot_v_d;
  logic [ROB_W-1:0]   slot_id_q  [NUM_SRC];
  logic [ROB_W-1:0]   slot_id_d  [NUM_SRC];
  logic [DATA_W-1:0]  slot_val_q [NUM_SRC];
  logic [DATA_W-1:0]  slot_val_d [NUM_SRC];

  // Round-robin pointer and registered broadcast
  logic [SRC_IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic                 cdb_valid_q, cdb_valid_d;
  logic [ROB_W-1:0]     cdb_rob_id_q, cdb_rob_id_d;
  logic [DATA_W-1:0]    cdb_val_q, cdb_val_d;
  logic [SRC_IDX_W-1:0] cdb_src_q, cdb_src_d;

  // Arbitration results
  logic                 grant_vld;
  logic [SRC_IDX_W-1:0] grant_idx;
  logic [NUM_SRC-1:0]   grant;
  logic [NUM_SRC-1:0]   accept;
  logic [NUM_SRC-1:0]   src_ready_w;
  logic [ROB_W-1:0]     in_id  [NUM_SRC];
  logic [DATA_W-1:0]    in_val [NUM_SRC];

  // Age-search and round-robin scratch
  logic [ROB_W-1:0]     cand_age;
  logic [ROB_W-1:0]     best_age;
  int                   rr_idx;
  logic [SRC_IDX_W-1:0] rr_sel;

  // Per-source handshake: a slot is free if empty, or if it is being granted
  // this cycle (the old entry leaves on the same edge the new one arrives).
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : gen_src
    assign in_id[gi]       = bus.src_rob_id[gi*ROB_W +: ROB_W];
    assign in_val[gi]      = bus.src_val[gi*DATA_W +: DATA_W];
    assign grant[gi]       = grant_vld && (grant_idx == SRC_IDX_W'(gi));
    assign src_ready_w[gi] = rdy_in & ~clear_in & (~slot_v_q[gi] | grant[gi]);
    assign accept[gi]      = bus.src_valid[gi] & src_ready_w[gi];
  end

  // Pick one valid slot: smallest distance from the ROB head, or first at/after rr_ptr.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand_age  = '0;
    best_age  = '0;
    rr_idx    = 0;
    rr_sel    = '0;
    if (AGE_PRIO != 0) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        cand_age = slot_id_q[i] - rob_head_in;
        // Strict compare keeps the lowest index on a duplicate id.
        if (slot_v_q[i] && (!grant_vld || (cand_age < best_age))) begin
          grant_vld = 1'b1;
          grant_idx = SRC_IDX_W'(i);
          best_age  = cand_age;
        end
      end
    end else begin
      for (int k = 0; k < NUM_SRC; k++) begin
        rr_idx = int'(rr_ptr_q) + k;
        if (rr_idx >= NUM_SRC) rr_idx = rr_idx - NUM_SRC;
        rr_sel = SRC_IDX_W'(rr_idx);
        if (!grant_vld && slot_v_q[rr_sel]) begin
          grant_vld = 1'b1;
          grant_idx = rr_sel;
        end
      end
    end
  end

  // Next state: flush beats grant and capture; a stalled pipeline holds everything.
  always_comb begin
    slot_v_d     = slot_v_q;
    rr_ptr_d     = rr_ptr_q;
    cdb_valid_d  = cdb_valid_q;
    cdb_rob_id_d = cdb_rob_id_q;
    cdb_val_d    = cdb_val_q;
    cdb_src_d    = cdb_src_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      slot_id_d[i]  = slot_id_q[i];
      slot_val_d[i] = slot_val_q[i];
      if (accept[i]) begin
        slot_id_d[i]  = in_id[i];
        slot_val_d[i] = in_val[i];
      end
    end
    if (rdy_in) begin
      if (clear_in) begin
        slot_v_d    = '0;
        cdb_valid_d = 1'b0;
        rr_ptr_d    = '0;
      end else begin
        // A granted slot empties unless refilled on the same edge.
        slot_v_d = accept | (slot_v_q & ~grant);
        if (grant_vld) begin
          cdb_valid_d  = 1'b1;
          cdb_rob_id_d = slot_id_q[grant_idx];
          cdb_val_d    = slot_val_q[grant_idx];
          cdb_src_d    = grant_idx;
          rr_ptr_d     = (grant_idx == SRC_IDX_W'(NUM_SRC-1)) ? '0 : grant_idx + 1'b1;
        end else begin
          cdb_valid_d = 1'b0;
        end
      end
    end
  end

  // State registers with asynchronous active-low reset; in-flight results are dropped.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      slot_v_q     <= '0;
      rr_ptr_q     <= '0;
      cdb_valid_q  <= 1'b0;
      cdb_rob_id_q <= '0;
      cdb_val_q    <= '0;
      cdb_src_q    <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        slot_id_q[i]  <= '0;
        slot_val_q[i] <= '0;
      end
    end else begin
      slot_v_q     <= slot_v_d;
      rr_ptr_q     <= rr_ptr_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_rob_id_q <= cdb_rob_id_d;
      cdb_val_q    <= cdb_val_d;
      cdb_src_q    <= cdb_src_d;
      for (int i = 0; i < NUM_SRC; i++) begin
        slot_id_q[i]  <= slot_id_d[i];
        slot_val_q[i] <= slot_val_d[i];
      end
    end
  end

  assign bus.src_ready  = src_ready_w;
  assign bus.cdb_valid  = cdb_valid_q;
  assign bus.cdb_rob_id = cdb_rob_id_q;
  assign bus.cdb_val    = cdb_val_q;
  assign bus.cdb_src    = cdb_src_q;
  assign bus.pending    = |slot_v_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: one age-priority instance and one
// round-robin instance share clock, reset, ready, flush and ROB head.
module tb_cdb_arbiter;
  localparam int NS = 3;
  localparam int IW = 2;
  localparam int RW = 5;
  localparam int DW = 32;

  logic          clk_in = 1'b0;
  logic          rst_n_in;
  logic          rdy_in;
  logic          clear_in;
  logic [RW-1:0] rob_head_in;

  int n_checks = 0;
  int n_errors = 0;

  cdb_arbiter_if #(.NUM_SRC(NS), .SRC_IDX_W(IW), .ROB_W(RW), .DATA_W(DW)) bus_a ();
  cdb_arbiter_if #(.NUM_SRC(NS), .SRC_IDX_W(IW), .ROB_W(RW), .DATA_W(DW)) bus_r ();

  cdb_arbiter #(.NUM_SRC(NS), .SRC_IDX_W(IW), .ROB_W(RW), .DATA_W(DW), .AGE_PRIO(1)) u_age (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .rdy_in      (rdy_in),
    .clear_in    (clear_in),
    .rob_head_in (rob_head_in),
    .bus         (bus_a)
  );

  cdb_arbiter #(.NUM_SRC(NS), .SRC_IDX_W(IW), .ROB_W(RW), .DATA_W(DW), .AGE_PRIO(0)) u_rr (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .rdy_in      (rdy_in),
    .clear_in    (clear_in),
    .rob_head_in (rob_head_in),
    .bus         (bus_r)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_a(input int i, input logic v, input logic [RW-1:0] id, input logic [DW-1:0] val);
    bus_a.src_valid[i]            = v;
    bus_a.src_rob_id[i*RW +: RW]  = id;
    bus_a.src_val[i*DW +: DW]     = val;
  endtask

  task automatic drive_r(input int i, input logic v, input logic [RW-1:0] id, input logic [DW-1:0] val);
    bus_r.src_valid[i]            = v;
    bus_r.src_rob_id[i*RW +: RW]  = id;
    bus_r.src_val[i*DW +: DW]     = val;
  endtask

  task automatic chk_cdb(input string tag, input logic [RW-1:0] id, input logic [DW-1:0] val, input logic [IW-1:0] src);
    chk({tag, "_valid"}, 32'(bus_a.cdb_valid), 32'd1);
    chk({tag, "_id"},    32'(bus_a.cdb_rob_id), 32'(id));
    chk({tag, "_val"},   bus_a.cdb_val, val);
    chk({tag, "_src"},   32'(bus_a.cdb_src), 32'(src));
    $display("cdb %s: id=%0d val=%0h src=%0d", tag, bus_a.cdb_rob_id, bus_a.cdb_val, bus_a.cdb_src);
  endtask

  initial begin
    rst_n_in    = 1'b0;
    rdy_in      = 1'b1;
    clear_in    = 1'b0;
    rob_head_in = '0;
    bus_a.src_valid = '0; bus_a.src_rob_id = '0; bus_a.src_val = '0;
    bus_r.src_valid = '0; bus_r.src_rob_id = '0; bus_r.src_val = '0;
    #1;
    // Reset state (async, no edge yet)
    chk("rst_valid",   32'(bus_a.cdb_valid), 32'd0);
    chk("rst_id",      32'(bus_a.cdb_rob_id), 32'd0);
    chk("rst_val",     bus_a.cdb_val, 32'd0);
    chk("rst_src",     32'(bus_a.cdb_src), 32'd0);
    chk("rst_pending", 32'(bus_a.pending), 32'd0);
    chk("rst_ready",   32'(bus_a.src_ready), 32'h7);
    tick(); tick();
    rst_n_in = 1'b1;
    tick();

    // 1: single source, two-edge latency, one-cycle pulse
    drive_a(0, 1'b1, 5'd3, 32'h55);
    tick();
    chk("t1_lat_valid", 32'(bus_a.cdb_valid), 32'd0);
    chk("t1_pending",   32'(bus_a.pending), 32'd1);
    drive_a(0, 1'b0, 5'd0, 32'h0);
    tick();
    chk_cdb("t1", 5'd3, 32'h55, 2'd0);
    chk("t1_pending_done", 32'(bus_a.pending), 32'd0);
    tick();
    chk("t1_pulse", 32'(bus_a.cdb_valid), 32'd0);

    // 1b: four back-to-back results from source 0
    for (int k = 0; k < 4; k++) begin
      drive_a(0, 1'b1, 5'(4 + k), 32'h100 + 32'(k));
      #1;
      chk("t1b_ready0", 32'(bus_a.src_ready[0]), 32'd1);
      tick();
      if (k == 0) chk("t1b_first", 32'(bus_a.cdb_valid), 32'd0);
      else        chk_cdb("t1b", 5'(3 + k), 32'h100 + 32'(k - 1), 2'd0);
    end
    drive_a(0, 1'b0, 5'd0, 32'h0);
    tick();
    chk_cdb("t1b_last", 5'd7, 32'h103, 2'd0);
    tick();
    chk("t1b_end", 32'(bus_a.cdb_valid), 32'd0);

    // 2: age order around the ROB wrap, head=30
    rob_head_in = 5'd30;
    drive_a(0, 1'b1, 5'd2,  32'hA0);
    drive_a(1, 1'b1, 5'd31, 32'hA1);
    drive_a(2, 1'b1, 5'd30, 32'hA2);
    tick();
    for (int i = 0; i < NS; i++) drive_a(i, 1'b0, 5'd0, 32'h0);
    chk("t2_lat", 32'(bus_a.cdb_valid), 32'd0);
    tick(); chk_cdb("t2_a", 5'd30, 32'hA2, 2'd2);
    tick(); chk_cdb("t2_b", 5'd31, 32'hA1, 2'd1);
    tick(); chk_cdb("t2_c", 5'd2,  32'hA0, 2'd0);
    chk("t2_pending", 32'(bus_a.pending), 32'd0);
    tick(); chk("t2_end", 32'(bus_a.cdb_valid), 32'd0);
    rob_head_in = 5'd0;

    // 3: round robin with all sources continuously valid
    for (int s = 0; s < NS; s++) drive_r(s, 1'b1, 5'(10 + s), 32'hB0 + 32'(s));
    tick();
    for (int k = 0; k < 6; k++) begin
      chk("t3_ready", 32'(bus_r.src_ready), 32'(1 << (k % 3)));
      tick();
      chk("t3_valid", 32'(bus_r.cdb_valid), 32'd1);
      chk("t3_src",   32'(bus_r.cdb_src), 32'(k % 3));
      chk("t3_val",   bus_r.cdb_val, 32'hB0 + 32'(k % 3));
      $display("rr cdb: src=%0d id=%0d val=%0h", bus_r.cdb_src, bus_r.cdb_rob_id, bus_r.cdb_val);
    end
    for (int s = 0; s < NS; s++) drive_r(s, 1'b0, 5'd0, 32'h0);
    for (int s = 0; s < NS; s++) begin
      tick();
      chk("t3_drain_src", 32'(bus_r.cdb_src), 32'(s));
      chk("t3_drain_valid", 32'(bus_r.cdb_valid), 32'd1);
    end
    tick();
    chk("t3_end_valid",   32'(bus_r.cdb_valid), 32'd0);
    chk("t3_end_pending", 32'(bus_r.pending), 32'd0);

    // 4: backpressure on source 1 (head=0, id 9 loses to ids 1 and 2)
    drive_a(0, 1'b1, 5'd1, 32'h100);
    drive_a(1, 1'b1, 5'd9, 32'h900);
    drive_a(2, 1'b1, 5'd2, 32'h200);
    tick();
    drive_a(0, 1'b0, 5'd0, 32'h0);
    drive_a(2, 1'b0, 5'd0, 32'h0);
    drive_a(1, 1'b1, 5'd12, 32'hC00);
    #1;
    chk("t4_ready1_a", 32'(bus_a.src_ready[1]), 32'd0);
    tick(); chk_cdb("t4_a", 5'd1, 32'h100, 2'd0);
    chk("t4_ready1_b", 32'(bus_a.src_ready[1]), 32'd0);
    tick(); chk_cdb("t4_b", 5'd2, 32'h200, 2'd2);
    chk("t4_ready1_c", 32'(bus_a.src_ready[1]), 32'd1);
    tick(); chk_cdb("t4_c", 5'd9, 32'h900, 2'd1);
    drive_a(1, 1'b0, 5'd0, 32'h0);
    chk("t4_pending", 32'(bus_a.pending), 32'd1);
    tick(); chk_cdb("t4_d", 5'd12, 32'hC00, 2'd1);
    tick(); chk("t4_end", 32'(bus_a.cdb_valid), 32'd0);

    // 5: flush with three full slots and a new result in the flush cycle
    drive_a(0, 1'b1, 5'd4, 32'h44);
    drive_a(1, 1'b1, 5'd5, 32'h45);
    drive_a(2, 1'b1, 5'd6, 32'h46);
    tick();
    drive_a(0, 1'b1, 5'd7, 32'h47);
    drive_a(1, 1'b0, 5'd0, 32'h0);
    drive_a(2, 1'b0, 5'd0, 32'h0);
    clear_in = 1'b1;
    #1;
    chk("t5_ready", 32'(bus_a.src_ready), 32'd0);
    tick();
    clear_in = 1'b0;
    drive_a(0, 1'b0, 5'd0, 32'h0);
    chk("t5_valid",   32'(bus_a.cdb_valid), 32'd0);
    chk("t5_pending", 32'(bus_a.pending), 32'd0);
    tick();
    chk("t5_valid2",   32'(bus_a.cdb_valid), 32'd0);
    chk("t5_pending2", 32'(bus_a.pending), 32'd0);

    // 6: stall with two pending, attempted capture is refused
    drive_a(0, 1'b1, 5'd1, 32'h11);
    drive_a(1, 1'b1, 5'd3, 32'h33);
    drive_a(2, 1'b1, 5'd5, 32'h55);
    tick();
    for (int i = 0; i < NS; i++) drive_a(i, 1'b0, 5'd0, 32'h0);
    tick();
    chk_cdb("t6_pre", 5'd1, 32'h11, 2'd0);
    rdy_in = 1'b0;
    drive_a(0, 1'b1, 5'd8, 32'h88);
    #1;
    chk("t6_ready", 32'(bus_a.src_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_cdb("t6_frozen", 5'd1, 32'h11, 2'd0);
      chk("t6_pending", 32'(bus_a.pending), 32'd1);
    end
    rdy_in = 1'b1;
    drive_a(0, 1'b0, 5'd0, 32'h0);
    tick(); chk_cdb("t6_a", 5'd3, 32'h33, 2'd1);
    tick(); chk_cdb("t6_b", 5'd5, 32'h55, 2'd2);
    tick();
    chk("t6_end_valid",   32'(bus_a.cdb_valid), 32'd0);
    chk("t6_end_pending", 32'(bus_a.pending), 32'd0);

    // 6b: asynchronous reset in mid-stream
    drive_a(0, 1'b1, 5'd9,  32'h99);
    drive_a(1, 1'b1, 5'd10, 32'hAA);
    tick();
    drive_a(0, 1'b0, 5'd0, 32'h0);
    drive_a(1, 1'b0, 5'd0, 32'h0);
    tick();
    chk_cdb("t6r_pre", 5'd9, 32'h99, 2'd0);
    chk("t6r_pre_pending", 32'(bus_a.pending), 32'd1);
    #1;
    rst_n_in = 1'b0;
    #1;
    chk("t6r_valid",   32'(bus_a.cdb_valid), 32'd0);
    chk("t6r_pending", 32'(bus_a.pending), 32'd0);
    chk("t6r_id",      32'(bus_a.cdb_rob_id), 32'd0);
    chk("t6r_val",     bus_a.cdb_val, 32'd0);
    #1;
    rst_n_in = 1'b1;
    tick();
    chk("t6r_after_valid",   32'(bus_a.cdb_valid), 32'd0);
    chk("t6r_after_pending", 32'(bus_a.pending), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
